// File: rtl/vm_controller.sv
// Vending machine sequencing controller: credit accumulation, item selection,
// dispense handshake and coin-at-a-time change return.
module vm_controller #(
  parameter int unsigned PRICE0     = 75,
  parameter int unsigned PRICE1     = 100,
  parameter int unsigned PRICE2     = 125,
  parameter int unsigned PRICE3     = 150,
  parameter int unsigned MAX_CREDIT = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        coin_valid_i,
  input  logic [7:0]  coin_value_i,
  input  logic        sel_valid_i,
  input  logic [1:0]  sel_item_i,
  input  logic        cancel_i,
  output logic        dispense_valid_o,
  output logic [1:0]  dispense_item_o,
  input  logic        dispense_ready_i,
  output logic        change_valid_o,
  output logic [7:0]  change_coin_o,
  input  logic        change_ready_i,
  output logic [15:0] credit_o,
  output logic        coin_reject_o,
  output logic        sel_short_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StVend, StChange} state_e;

  state_e      state_q;
  logic [15:0] credit_q;
  logic        dispense_valid_q;
  logic [1:0]  dispense_item_q;
  logic        change_valid_q;
  logic [7:0]  change_coin_q;
  logic        coin_reject_q;
  logic        sel_short_q;
  logic        busy_q;

  logic [16:0] coin_sum;
  logic        coin_legal;
  logic        coin_ok;
  logic [15:0] price_sel;
  logic [15:0] credit_after_change;

  // Largest legal denomination that fits in the given credit.
  function automatic logic [7:0] largest_coin(input logic [15:0] c);
    if (c >= 16'd100)     return 8'd100;
    else if (c >= 16'd25) return 8'd25;
    else if (c >= 16'd10) return 8'd10;
    else if (c >= 16'd5)  return 8'd5;
    else                  return 8'd0;
  endfunction

  assign coin_sum   = {1'b0, credit_q} + {9'd0, coin_value_i};
  assign coin_legal = (coin_value_i == 8'd5)  || (coin_value_i == 8'd10) ||
                      (coin_value_i == 8'd25) || (coin_value_i == 8'd100);
  assign coin_ok    = coin_legal && (coin_sum <= 17'(MAX_CREDIT));

  always_comb begin
    price_sel = 16'(PRICE0);
    unique case (sel_item_i)
      2'd0: price_sel = 16'(PRICE0);
      2'd1: price_sel = 16'(PRICE1);
      2'd2: price_sel = 16'(PRICE2);
      2'd3: price_sel = 16'(PRICE3);
      default: price_sel = 16'(PRICE0);
    endcase
  end

  assign credit_after_change = credit_q - {8'd0, change_coin_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      credit_q         <= '0;
      dispense_valid_q <= 1'b0;
      dispense_item_q  <= '0;
      change_valid_q   <= 1'b0;
      change_coin_q    <= '0;
      coin_reject_q    <= 1'b0;
      sel_short_q      <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      coin_reject_q <= 1'b0;
      sel_short_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cancel_i) begin
            coin_reject_q <= coin_valid_i;
            if (credit_q != 16'd0) begin
              state_q        <= StChange;
              change_valid_q <= 1'b1;
              change_coin_q  <= largest_coin(credit_q);
              busy_q         <= 1'b1;
            end
          end else if (sel_valid_i) begin
            coin_reject_q <= coin_valid_i;
            if (credit_q >= price_sel) begin
              state_q          <= StVend;
              credit_q         <= credit_q - price_sel;
              dispense_valid_q <= 1'b1;
              dispense_item_q  <= sel_item_i;
              busy_q           <= 1'b1;
            end else begin
              sel_short_q <= 1'b1;
            end
          end else if (coin_valid_i) begin
            if (coin_ok) credit_q <= coin_sum[15:0];
            else         coin_reject_q <= 1'b1;
          end
        end
        StVend: begin
          coin_reject_q <= coin_valid_i;
          if (dispense_ready_i) begin
            dispense_valid_q <= 1'b0;
            if (credit_q != 16'd0) begin
              state_q        <= StChange;
              change_valid_q <= 1'b1;
              change_coin_q  <= largest_coin(credit_q);
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        StChange: begin
          coin_reject_q <= coin_valid_i;
          if (change_ready_i) begin
            credit_q      <= credit_after_change;
            change_coin_q <= largest_coin(credit_after_change);
            if (credit_after_change == 16'd0) begin
              state_q        <= StIdle;
              change_valid_q <= 1'b0;
              busy_q         <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dispense_valid_o = dispense_valid_q;
  assign dispense_item_o  = dispense_item_q;
  assign change_valid_o   = change_valid_q;
  assign change_coin_o    = change_coin_q;
  assign credit_o         = credit_q;
  assign coin_reject_o    = coin_reject_q;
  assign sel_short_o      = sel_short_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_vm_controller.sv
// Directed self-checking bench for vm_controller with hand-computed expectations.
module tb_vm_controller;

  logic        clk;
  logic        rst_n;
  logic        coin_valid;
  logic [7:0]  coin_value;
  logic        sel_valid;
  logic [1:0]  sel_item;
  logic        cancel;
  logic        dispense_valid;
  logic [1:0]  dispense_item;
  logic        dispense_ready;
  logic        change_valid;
  logic [7:0]  change_coin;
  logic        change_ready;
  logic [15:0] credit;
  logic        coin_reject;
  logic        sel_short;
  logic        busy;

  int vectors;
  int miscompares;

  vm_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .coin_valid_i     (coin_valid),
    .coin_value_i     (coin_value),
    .sel_valid_i      (sel_valid),
    .sel_item_i       (sel_item),
    .cancel_i         (cancel),
    .dispense_valid_o (dispense_valid),
    .dispense_item_o  (dispense_item),
    .dispense_ready_i (dispense_ready),
    .change_valid_o   (change_valid),
    .change_coin_o    (change_coin),
    .change_ready_i   (change_ready),
    .credit_o         (credit),
    .coin_reject_o    (coin_reject),
    .sel_short_o      (sel_short),
    .busy_o           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each stimulus task drives for one clock and returns at the following negedge.
  task automatic do_coin(input logic [7:0] v);
    @(negedge clk);
    coin_valid = 1'b1;
    coin_value = v;
    @(negedge clk);
    coin_valid = 1'b0;
    coin_value = 8'd0;
  endtask

  task automatic do_sel(input logic [1:0] i);
    @(negedge clk);
    sel_valid = 1'b1;
    sel_item  = i;
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
  endtask

  task automatic do_dispense_hs();
    @(negedge clk);
    dispense_ready = 1'b1;
    @(negedge clk);
    dispense_ready = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    coin_valid = 1'b0;
    coin_value = 8'd0;
    sel_valid = 1'b0;
    sel_item = 2'd0;
    cancel = 1'b0;
    dispense_ready = 1'b0;
    change_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dv", 32'(dispense_valid), 0);
    chk("rst_ditem", 32'(dispense_item), 0);
    chk("rst_cv", 32'(change_valid), 0);
    chk("rst_ccoin", 32'(change_coin), 0);
    chk("rst_reject", 32'(coin_reject), 0);
    chk("rst_short", 32'(sel_short), 0);
    rst_n = 1'b1;

    // Exact payment for item 0, no change
    do_coin(8'd25);
    chk("t1_c25", 32'(credit), 25);
    do_coin(8'd25);
    do_coin(8'd25);
    chk("t1_c75", 32'(credit), 75);
    do_sel(2'd0);
    chk("t1_dv", 32'(dispense_valid), 1);
    chk("t1_item", 32'(dispense_item), 0);
    chk("t1_credit", 32'(credit), 0);
    chk("t1_busy", 32'(busy), 1);
    do_dispense_hs();
    chk("t1_dv_low", 32'(dispense_valid), 0);
    chk("t1_busy_low", 32'(busy), 0);
    chk("t1_cv", 32'(change_valid), 0);
    @(negedge clk);
    chk("t1_cv_later", 32'(change_valid), 0);

    // Overpay for item 2, three quarters of change back-to-back
    do_coin(8'd100);
    do_coin(8'd100);
    chk("t2_c200", 32'(credit), 200);
    do_sel(2'd2);
    chk("t2_credit", 32'(credit), 75);
    chk("t2_item", 32'(dispense_item), 2);
    chk("t2_dv", 32'(dispense_valid), 1);
    do_dispense_hs();
    chk("t2_dv_low", 32'(dispense_valid), 0);
    chk("t2_cv", 32'(change_valid), 1);
    chk("t2_coin0", 32'(change_coin), 25);
    chk("t2_busy", 32'(busy), 1);
    change_ready = 1'b1;
    @(negedge clk);
    chk("t2_cr1", 32'(credit), 50);
    chk("t2_coin1", 32'(change_coin), 25);
    chk("t2_cv1", 32'(change_valid), 1);
    @(negedge clk);
    chk("t2_cr2", 32'(credit), 25);
    chk("t2_coin2", 32'(change_coin), 25);
    @(negedge clk);
    change_ready = 1'b0;
    chk("t2_cr3", 32'(credit), 0);
    chk("t2_cv3", 32'(change_valid), 0);
    chk("t2_busy3", 32'(busy), 0);

    // Cancel refunds mixed denominations, then an illegal coin
    do_coin(8'd25);
    do_coin(8'd10);
    do_coin(8'd5);
    chk("t3_c40", 32'(credit), 40);
    do_cancel();
    chk("t3_cv", 32'(change_valid), 1);
    chk("t3_coin0", 32'(change_coin), 25);
    chk("t3_credit", 32'(credit), 40);
    change_ready = 1'b1;
    @(negedge clk);
    chk("t3_cr1", 32'(credit), 15);
    chk("t3_coin1", 32'(change_coin), 10);
    @(negedge clk);
    chk("t3_cr2", 32'(credit), 5);
    chk("t3_coin2", 32'(change_coin), 5);
    @(negedge clk);
    change_ready = 1'b0;
    chk("t3_cr3", 32'(credit), 0);
    chk("t3_idle", 32'(busy), 0);
    do_coin(8'd7);
    chk("t3_rej7", 32'(coin_reject), 1);
    chk("t3_cr_after7", 32'(credit), 0);
    @(negedge clk);
    chk("t3_rej_pulse", 32'(coin_reject), 0);

    // Credit ceiling, then a short selection
    repeat (5) do_coin(8'd100);
    chk("t4_c500", 32'(credit), 500);
    do_coin(8'd5);
    chk("t4_rej_max", 32'(coin_reject), 1);
    chk("t4_c500b", 32'(credit), 500);
    do_cancel();
    chk("t4_coin100", 32'(change_coin), 100);
    change_ready = 1'b1;
    repeat (5) @(negedge clk);
    change_ready = 1'b0;
    chk("t4_drained", 32'(credit), 0);
    chk("t4_idle", 32'(busy), 0);
    do_coin(8'd100);
    do_sel(2'd3);
    chk("t4_short", 32'(sel_short), 1);
    chk("t4_credit", 32'(credit), 100);
    chk("t4_dv", 32'(dispense_valid), 0);
    chk("t4_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t4_short_pulse", 32'(sel_short), 0);

    // Dispense backpressure with a coin offered while vending
    do_coin(8'd25);
    chk("t5_c125", 32'(credit), 125);
    do_sel(2'd1);
    chk("t5_credit", 32'(credit), 25);
    do_coin(8'd10);
    chk("t5_rej", 32'(coin_reject), 1);
    chk("t5_cr_hold", 32'(credit), 25);
    chk("t5_dv1", 32'(dispense_valid), 1);
    chk("t5_item1", 32'(dispense_item), 1);
    @(negedge clk);
    chk("t5_dv2", 32'(dispense_valid), 1);
    chk("t5_item2", 32'(dispense_item), 1);
    @(negedge clk);
    chk("t5_dv3", 32'(dispense_valid), 1);
    chk("t5_item3", 32'(dispense_item), 1);
    do_dispense_hs();
    chk("t5_dv_low", 32'(dispense_valid), 0);
    chk("t5_cv", 32'(change_valid), 1);
    chk("t5_coin", 32'(change_coin), 25);
    change_ready = 1'b1;
    @(negedge clk);
    change_ready = 1'b0;
    chk("t5_cr0", 32'(credit), 0);
    chk("t5_idle", 32'(busy), 0);

    // Asynchronous reset mid-change discards credit
    do_coin(8'd25);
    do_coin(8'd25);
    do_cancel();
    chk("t6_cv", 32'(change_valid), 1);
    chk("t6_credit", 32'(credit), 50);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_credit", 32'(credit), 0);
    chk("t6_rst_cv", 32'(change_valid), 0);
    chk("t6_rst_coin", 32'(change_coin), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_coin(8'd10);
    chk("t6_c10", 32'(credit), 10);
    chk("t6_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vm_controller.md
# vm_controller

Sequencing controller for the vending machine datapath. It accepts coins and accumulates a credit total, then validates an item selection against a per-item price table. It issues a dispense request with a valid/ready handshake and returns change one coin at a time. It sits between the coin/keypad front end and the dispense/change mechanisms, and owns all vending state.

## Interface
- PRICE0, 75: price of item 0, in cents
- PRICE1, 100: price of item 1, in cents
- PRICE2, 125: price of item 2, in cents
- PRICE3, 150: price of item 3, in cents
- MAX_CREDIT, 500: maximum credit that may be held, in cents

- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- coin_valid  in  1  one-cycle strobe, a coin is present
- coin_value  in  8  coin value in cents
- sel_valid  in  1  one-cycle strobe, an item is selected
- sel_item  in  2  selected item index
- cancel  in  1  one-cycle strobe, refund the held credit
- dispense_valid  out  1  dispense request pending
- dispense_item  out  2  item to dispense; stable while dispense_valid is high
- dispense_ready  in  1  dispenser accepts the request
- change_valid  out  1  change coin pending
- change_coin  out  8  value of the change coin; stable while change_valid is high
- change_ready  in  1  coin hopper accepts the coin
- credit  out  16  current credit in cents
- coin_reject  out  1  one-cycle pulse, the coin was refused
- sel_short  out  1  one-cycle pulse, credit is below the price of the selection
- busy  out  1  high whenever the state is not IDLE

## Operation
- State machine states: IDLE, VEND, CHANGE.
- In IDLE, the input priority is cancel > sel_valid > coin_valid. A coin presented in the same cycle as a cancel or selection is rejected.
- Coins:
  - Legal denominations are 5, 10, 25 and 100.
  - A coin is accepted only if it is a legal denomination and credit + coin_value ≤ MAX_CREDIT. Accepting it adds the value to credit.
  - Any other coin pulses coin_reject.
  - Any coin_valid arriving in VEND or CHANGE pulses coin_reject.
- Selection:
  - If credit ≥ PRICE[sel_item]: subtract the price from credit, latch dispense_item and go to VEND.
  - Otherwise pulse sel_short. Credit and state are unchanged.
- Cancel:
  - With credit > 0, go to CHANGE.
  - With credit = 0, nothing happens.
- VEND:
  - dispense_valid stays high until the cycle in which dispense_valid and dispense_ready are both high.
  - After that handshake, go to CHANGE if credit > 0, else to IDLE.
- CHANGE:
  - change_coin is the largest legal denomination ≤ credit.
  - Each change_valid & change_ready handshake subtracts change_coin from credit.
  - When credit reaches 0, go to IDLE.
  - Because every legal denomination is a multiple of 5, credit is always a multiple of 5 and change always terminates exactly.
- sel_valid and cancel are ignored outside IDLE. No pulse is produced for them.
- Arithmetic: credit is an unsigned 16-bit register. The MAX_CREDIT check guarantees it never overflows. The price comparison is unsigned, and the subtraction never underflows.

## Timing
- Reset values: state IDLE; every output 0, including credit, dispense_item and change_coin.
- Reset asserted mid-operation clears everything at once. Held credit is discarded with no refund.
- All outputs are registered.
- Coin accepted at edge N → credit is updated at N+1.
- coin_reject and sel_short are high for exactly the one cycle following the offending strobe.
- sel_valid at edge N with sufficient credit → dispense_valid, dispense_item and the reduced credit are all visible at N+1. busy is high from N+1.
- Dispense handshake at edge M:
  - dispense_valid is low at M+1.
  - If credit > 0, change_valid is high at M+1.
  - If credit = 0, busy is low at M+1.
- Change handshake at edge K:
  - credit and change_coin are updated at K+1.
  - change_valid stays high back-to-back until the final coin.
  - busy is low the cycle after the last handshake.
- Backpressure: while ready is low, valid and its data hold indefinitely and unchanged.
- cancel at edge N in IDLE with credit > 0 → change_valid high at N+1.

## Test plan
- Coins 25, 25, 25 then sel_item 0 → dispense_item = 0, credit = 0. After the handshake, busy = 0 and change_valid never asserts.
- Coins 100, 100 then sel_item 2 → credit = 75 and dispense. Then change coins 25, 25, 25, then IDLE with credit = 0.
- Coins 25, 10, 5 then cancel → change coins 25, 10, 5. Then coin 7 → coin_reject pulse, credit unchanged at 0.
- Credit 500 then coin 5 → coin_reject. Then sel_item 3 with credit 100 → sel_short, credit stays 100, no dispense.
- Hold dispense_ready low for 3 cycles → dispense_valid and dispense_item stable for all 3. A coin offered during that time → coin_reject.
- Assert rst_n low during CHANGE with credit 50 → all outputs 0 immediately, state IDLE. A subsequent coin 10 → credit = 10.
